// File: rtl/pe.sv
// Processing element: two-stage signed multiply-add pipeline with a valid flag.
// Optional ReLU on the result when the PE_RELU_EN macro is defined.
module pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ifmap,
  input  logic [DATA_W-1:0] weight,
  input  logic [ACC_W-1:0]  bias,
  input  logic              en,
  output logic [ACC_W-1:0]  opsum,
  output logic              valid
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] ifmap_ext_s;
  logic signed [PROD_W-1:0] weight_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic        [PROD_W-1:0] prod_r;
  logic        [ACC_W-1:0]  bias_r;
  logic                     v1_r;
  logic        [ACC_W-1:0]  sum_s;
  logic        [ACC_W-1:0]  res_s;

  // Sign-extend the product to the accumulator width before the bias add.
  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    sext_prod = ACC_W'($signed(p));
  endfunction

  // Full-precision product: operands widened first so (-128)*(-128) survives.
  always_comb begin
    ifmap_ext_s  = {{DATA_W{ifmap[DATA_W-1]}}, ifmap};
    weight_ext_s = {{DATA_W{weight[DATA_W-1]}}, weight};
    prod_s       = ifmap_ext_s * weight_ext_s;
  end

  // Stage 1: capture product and bias when operands are valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r <= {PROD_W{1'b0}};
      bias_r <= {ACC_W{1'b0}};
      v1_r   <= 1'b0;
    end else if (en) begin
      prod_r <= prod_s;
      bias_r <= bias;
      v1_r   <= 1'b1;
    end else begin
      v1_r   <= 1'b0;
    end
  end

  // Wrapped sum with optional ReLU clamp of negative results.
  always_comb begin
    sum_s = sext_prod(prod_r) + bias_r;
    res_s = sum_s;
`ifdef PE_RELU_EN
    if (sum_s[ACC_W-1]) begin
      res_s = {ACC_W{1'b0}};
    end else begin
      res_s = sum_s;
    end
`endif
  end

  // Stage 2: registered result; opsum holds through bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opsum <= {ACC_W{1'b0}};
      valid <= 1'b0;
    end else if (v1_r) begin
      opsum <= res_s;
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed corner cases plus randomized streams
// against a queue-based arithmetic reference model.
module tb_pe;

  logic        clk;
  logic        rst;
  logic [7:0]  ifmap;
  logic [7:0]  weight;
  logic [31:0] bias;
  logic        en;
  logic [31:0] opsum;
  logic        valid;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] exp_q[$];
  logic        prev_en;
  logic        exp_valid;
  logic [31:0] exp_opsum;
  int          n_results;

  pe #(.DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .ifmap(ifmap), .weight(weight),
    .bias(bias), .en(en), .opsum(opsum), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mac(input logic [7:0] a, input logic [7:0] w,
                                          input logic [31:0] b);
    longint p;
    longint s;
    logic [31:0] r;
    p = longint'($signed(a)) * longint'($signed(w));
    s = p + longint'($signed(b));
    r = s[31:0];
`ifdef PE_RELU_EN
    if (r[31]) r = 32'h0000_0000;
`endif
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    prev_en   = 1'b0;
    exp_valid = 1'b0;
    exp_opsum = 32'h0000_0000;
  endtask

  // Drive one operand set (from a negedge), clock it, then check at the next negedge.
  task automatic step(input logic e, input logic [7:0] a, input logic [7:0] w,
                      input logic [31:0] b);
    ifmap  = a;
    weight = w;
    bias   = b;
    en     = e;
    @(posedge clk);
    exp_valid = prev_en;
    if (prev_en) begin
      exp_opsum = exp_q.pop_front();
      n_results++;
    end
    prev_en = e;
    if (e) exp_q.push_back(ref_mac(a, w, b));
    @(negedge clk);
    chk("valid", {31'd0, valid}, {31'd0, exp_valid});
    chk("opsum", opsum, exp_opsum);
  endtask

  initial begin
    logic [31:0] c_neg;
    logic [31:0] c_wrap;
    int          start_res;
    rst    = 1'b0;
    ifmap  = 8'h00;
    weight = 8'h00;
    bias   = 32'h0000_0000;
    en     = 1'b0;
    n_results = 0;
    model_clear();
`ifdef PE_RELU_EN
    c_neg  = 32'h0000_0000;
    c_wrap = 32'h0000_0000;
`else
    c_neg  = 32'hFFFF_FFFE;
    c_wrap = 32'h8000_3FFF;
`endif

    #1;
    chk("rst_opsum", opsum, 32'h0000_0000);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic MAC: one-cycle valid pulse two edges after sampling.
    step(1'b1, 8'h03, 8'h04, 32'h0000_0010);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);
    chk("mac_const", opsum, 32'h0000_001C);
    chk("mac_valid", {31'd0, valid}, 32'd1);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);
    chk("mac_pulse_end", {31'd0, valid}, 32'd0);

    step(1'b1, 8'hFF, 8'h02, 32'h0000_0000);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);
    chk("signed_const", opsum, c_neg);

    step(1'b1, 8'h80, 8'h80, 32'h7FFF_FFFF);
    step(1'b1, 8'h80, 8'h80, 32'h0000_0000);
    chk("wrap_const", opsum, c_wrap);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);
    chk("extreme_const", opsum, 32'h0000_4000);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);

    // Streaming: 16 random sets, bubbles on cycles 5 and 9, then drain.
    start_res = n_results;
    for (int i = 0; i < 16; i++) begin
      step((i == 5 || i == 9) ? 1'b0 : 1'b1, 8'($urandom), 8'($urandom), $urandom);
    end
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);
    chk("stream_count", 32'(n_results - start_res), 32'd14);

    // Random enable pattern.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), $urandom);
    end

    // Reset mid-stream with a result in flight.
    step(1'b1, 8'h11, 8'h22, 32'h0000_0333);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_opsum", opsum, 32'h0000_0000);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    chk("inrst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'($urandom), 8'($urandom), $urandom);
    end

    // Capture on the first edge after release.
    step(1'b1, 8'h7F, 8'h7F, 32'hFFFF_0000);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);
    step(1'b0, 8'h00, 8'h00, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pe.md
# pe

Processing element for the convolution/MAC datapath: multiplies one signed 8-bit input-feature-map value by one signed 8-bit weight and adds a signed 32-bit bias. The result is produced through a two-stage pipeline with a valid flag. It is the leaf compute cell instantiated by the PE array; operands arrive one set per clock and results leave one per clock, with no back-pressure.

## Interface
- `DATA_W`, default 8: width of `ifmap` and `weight`, two's complement.
- `ACC_W`, default 32: width of `bias` and `opsum`, two's complement; must be at least 2*`DATA_W`.
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: reset, asynchronous, active-low. The port name is `rst`; the asserted level is 0.
- `ifmap` input `DATA_W`: signed activation operand.
- `weight` input `DATA_W`: signed weight operand.
- `bias` input `ACC_W`: signed bias added to the product.
- `en` input 1: operand-valid strobe; operands are sampled on a rising edge only when `en`=1.
- `opsum` output `ACC_W`: signed result, registered.
- `valid` output 1: high for exactly the cycles in which `opsum` holds a new result.

## Operation
- Stage 1, on a rising edge with `en`=1:
  - `prod_r` <= sign-extended `ifmap` * `weight`, a full-precision 2*`DATA_W` signed product.
  - `bias_r` <= `bias`.
  - `v1` <= 1.
- Stage 1, on a rising edge with `en`=0:
  - `v1` <= 0.
  - `prod_r` and `bias_r` hold their values.
- Stage 2, on a rising edge with `v1`=1:
  - `opsum` <= sign-extend(`prod_r`) + `bias_r`, modulo 2^`ACC_W` (two's-complement wrap, no saturation).
  - `valid` <= 1.
- Stage 2, on a rising edge with `v1`=0:
  - `valid` <= 0.
  - `opsum` holds its last value.
- Product range for 8-bit operands is -16256..16384. The worst case (-128)*(-128)=16384 is representable and must not be truncated.
- No internal accumulation: each result depends only on its own operand set.
- No state machine; the block is a pure pipeline of `v1` and `valid`.

## Timing
- Reset (`rst`=0, asynchronous, takes effect immediately):
  - `opsum`=0, `valid`=0.
  - `v1`=0, `prod_r`=0, `bias_r`=0.
- Release of reset is sampled synchronously. The first edge with `rst`=1 may already capture operands.
- Latency: operands sampled at edge k appear on `opsum` with `valid`=1 after edge k+1, i.e. 2 clock edges from sample to result.
- Throughput: one result per cycle. With `en` held high, `valid` is continuously high from the second edge onward.
- Bubble: `en`=0 at edge k produces `valid`=0 after edge k+1, and `opsum` is unchanged during that cycle.
- Reset mid-stream: all in-flight results are discarded. No `valid` pulse may appear for operands sampled before reset.
- Inputs must be stable around the rising edge only. There is no combinational path from any input to any output.

## Configuration
- `PE_RELU_EN`:
  - Defined: stage 2 writes 0 to `opsum` whenever the wrapped sum has its MSB set (ReLU). `valid` timing is unchanged.
  - Undefined: `opsum` is the raw wrapped signed sum.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst`=0 mid-cycle with a result in flight.
  - Required: `opsum`=0 and `valid`=0 immediately. No `valid` pulse after release while `en`=0.
- Basic MAC:
  - Stimulus: `ifmap`=0x03, `weight`=0x04, `bias`=0x00000010, `en`=1 for one cycle.
  - Required: 2 edges later `opsum`=0x0000001C, `valid`=1 for exactly one cycle.
- Signed operands:
  - Stimulus: `ifmap`=0xFF, `weight`=0x02, `bias`=0.
  - Required without `PE_RELU_EN`: `opsum`=0xFFFFFFFE.
  - Required with `PE_RELU_EN`: `opsum`=0x00000000.
- Extremes and wrap:
  - Stimulus: `ifmap`=0x80, `weight`=0x80, `bias`=0x7FFFFFFF.
  - Required: `opsum`=0x80003FFF, wrapped (no RELU).
  - Stimulus: same operands with `bias`=0.
  - Required: `opsum`=0x00004000.
- Streaming with bubbles:
  - Stimulus: 16 back-to-back random operand sets with `en` deasserted on cycles 5 and 9.
  - Required: 14 results in order, each matching a reference model.
  - Required: `valid` low exactly 2 edges after each bubble, with `opsum` held during it.
